// File: rtl/dcache_controller.sv
// ---------------------------------------------------------------------------
// dcache_controller
//
// Sequences a 32-line direct-mapped, write-back / write-allocate data cache
// between the CPU load/store stage and a line-wide data memory. Hits are
// served combinationally. A miss stalls the CPU, writes back a dirty victim,
// refills the line, allocates it and then lets the access replay as a hit.
//
// State table
//   state       | meaning
//   ------------+----------------------------------------------------------
//   S_IDLE      | serve hits; on a miss launch writeback or refill
//   S_WRITEBACK | memory line write of the dirty victim, wait for ack
//   S_REFILL    | memory line read of the missing line, wait for ack
//   S_ALLOCATE  | one cycle: write refilled line into the array (clean)
//
// Ports
//   clock_i, rst_i           clock, asynchronous active-low reset
//   cpu_req_i/write/addr/data CPU access (held until stall_o is low)
//   cpu_data_o, stall_o      load data and CPU stall
//   cache_*_o                array enable, write strobe, index and write data
//   cache_*_i                stored valid/dirty/tag/line at cache_index_o
//   mem_enable_o/write/addr/data  line request to memory (registered)
//   mem_ack_i, mem_data_i    one-cycle completion pulse and refill line
// ---------------------------------------------------------------------------
module dcache_controller #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int WORD_W = 32
) (
  input  logic                 clock_i,
  input  logic                 rst_i,
  // CPU side
  input  logic                 cpu_req_i,
  input  logic                 cpu_write_i,
  input  logic [ADDR_W-1:0]    cpu_addr_i,
  input  logic [WORD_W-1:0]    cpu_data_i,
  output logic [WORD_W-1:0]    cpu_data_o,
  output logic                 stall_o,
  // cache array side
  output logic                 cache_enable_o,
  output logic                 cache_write_o,
  output logic [4:0]           cache_index_o,
  output logic                 cache_valid_o,
  output logic                 cache_dirty_o,
  output logic [ADDR_W-11:0]   cache_tag_o,
  output logic [LINE_W-1:0]    cache_data_o,
  input  logic                 cache_valid_i,
  input  logic                 cache_dirty_i,
  input  logic [ADDR_W-11:0]   cache_tag_i,
  input  logic [LINE_W-1:0]    cache_data_i,
  // memory side
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic [LINE_W-1:0]    mem_data_o,
  input  logic                 mem_ack_i,
  input  logic [LINE_W-1:0]    mem_data_i
);

  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int IDX_W  = 5;
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int WSEL_W = $clog2(LINE_W / WORD_W);
  localparam int BIT_W  = $clog2(LINE_W);
  localparam int WBIT_W = $clog2(WORD_W);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_REFILL    = 2'd2,
    S_ALLOCATE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                mem_enable_q, mem_enable_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0]   mem_data_q, mem_data_d;
  logic [LINE_W-1:0]   refill_q, refill_d;

  logic [TAG_W-1:0]    addr_tag;
  logic [IDX_W-1:0]    addr_idx;
  logic [WSEL_W-1:0]   word_sel;
  logic [BIT_W-1:0]    word_lsb;
  logic                hit;
  logic [ADDR_W-1:0]   victim_addr;
  logic [ADDR_W-1:0]   refill_addr;
  logic [LINE_W-1:0]   merged_line;
  logic                unused_addr_bits;

  assign addr_tag    = cpu_addr_i[ADDR_W-1 -: TAG_W];
  assign addr_idx    = cpu_addr_i[OFF_W +: IDX_W];
  assign word_sel    = cpu_addr_i[OFF_W-1 -: WSEL_W];
  assign word_lsb    = {word_sel, {WBIT_W{1'b0}}};
  assign hit         = cache_valid_i && (cache_tag_i == addr_tag);
  assign victim_addr = {cache_tag_i, addr_idx, {OFF_W{1'b0}}};
  assign refill_addr = {cpu_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  // Byte-within-word bits play no part in a word-granular cache.
  assign unused_addr_bits = ^cpu_addr_i[OFF_W-WSEL_W-1:0];

  // CPU side: load data is always the addressed word of the stored line;
  // it is only meaningful on a hit in IDLE (stall_o low).
  assign cpu_data_o = cache_data_i[word_lsb +: WORD_W];
  assign stall_o    = (state_q != S_IDLE) || (cpu_req_i && !hit);

  assign cache_enable_o = cpu_req_i || (state_q != S_IDLE);
  assign cache_index_o  = addr_idx;

  always_comb begin
    merged_line = cache_data_i;
    merged_line[word_lsb +: WORD_W] = cpu_data_i;
  end

  // Array write port: either the store-hit merge in IDLE or the refilled
  // line during ALLOCATE. A store hit keeps the stored tag, which equals
  // the address tag by definition of a hit.
  always_comb begin
    cache_write_o = 1'b0;
    cache_valid_o = 1'b1;
    cache_dirty_o = 1'b1;
    cache_tag_o   = cache_tag_i;
    cache_data_o  = merged_line;
    if (state_q == S_ALLOCATE) begin
      cache_write_o = 1'b1;
      cache_dirty_o = 1'b0;
      cache_tag_o   = addr_tag;
      cache_data_o  = refill_q;
    end else if ((state_q == S_IDLE) && cpu_req_i && cpu_write_i && hit) begin
      cache_write_o = 1'b1;
    end
  end

  // Next-state and memory request. Memory outputs are registered and only
  // change on a state transition, so address/enable hold steady until ack.
  // A dropped cpu_req_i does not abort an in-flight miss.
  always_comb begin
    state_d      = state_q;
    mem_enable_d = mem_enable_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    refill_d     = refill_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_req_i && !hit) begin
          mem_enable_d = 1'b1;
          if (cache_valid_i && cache_dirty_i) begin
            state_d     = S_WRITEBACK;
            mem_write_d = 1'b1;
            mem_addr_d  = victim_addr;
            mem_data_d  = cache_data_i;
          end else begin
            state_d     = S_REFILL;
            mem_write_d = 1'b0;
            mem_addr_d  = refill_addr;
          end
        end
      end
      S_WRITEBACK: begin
        if (mem_ack_i) begin
          state_d     = S_REFILL;
          mem_write_d = 1'b0;
          mem_addr_d  = refill_addr;
        end
      end
      S_REFILL: begin
        if (mem_ack_i) begin
          state_d      = S_ALLOCATE;
          mem_enable_d = 1'b0;
          refill_d     = mem_data_i;
        end
      end
      S_ALLOCATE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= S_IDLE;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      refill_q     <= '0;
    end else begin
      state_q      <= state_d;
      mem_enable_q <= mem_enable_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      refill_q     <= refill_d;
    end
  end

  assign mem_enable_o = mem_enable_q;
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;

endmodule

// File: tb/tb_dcache_controller.sv
// ---------------------------------------------------------------------------
// tb_dcache_controller
//
// Surrounds the controller with a behavioural cache array and a line memory
// with programmable latency. Expected results come from a flat word-level
// view of memory plus a per-index valid/tag/dirty record of which line the
// cache should be holding.
// ---------------------------------------------------------------------------
module tb_dcache_controller;

  logic          clock_i = 1'b0;
  logic          rst_i   = 1'b0;
  logic          cpu_req_i = 1'b0;
  logic          cpu_write_i = 1'b0;
  logic [31:0]   cpu_addr_i = '0;
  logic [31:0]   cpu_data_i = '0;
  logic [31:0]   cpu_data_o;
  logic          stall_o;
  logic          cache_enable_o;
  logic          cache_write_o;
  logic [4:0]    cache_index_o;
  logic          cache_valid_o;
  logic          cache_dirty_o;
  logic [21:0]   cache_tag_o;
  logic [255:0]  cache_data_o;
  logic          cache_valid_i;
  logic          cache_dirty_i;
  logic [21:0]   cache_tag_i;
  logic [255:0]  cache_data_i;
  logic          mem_enable_o;
  logic          mem_write_o;
  logic [31:0]   mem_addr_o;
  logic [255:0]  mem_data_o;
  logic          mem_ack_i = 1'b0;
  logic [255:0]  mem_data_i = '0;

  always #5 clock_i = ~clock_i;

  dcache_controller dut (
    .clock_i        (clock_i),
    .rst_i          (rst_i),
    .cpu_req_i      (cpu_req_i),
    .cpu_write_i    (cpu_write_i),
    .cpu_addr_i     (cpu_addr_i),
    .cpu_data_i     (cpu_data_i),
    .cpu_data_o     (cpu_data_o),
    .stall_o        (stall_o),
    .cache_enable_o (cache_enable_o),
    .cache_write_o  (cache_write_o),
    .cache_index_o  (cache_index_o),
    .cache_valid_o  (cache_valid_o),
    .cache_dirty_o  (cache_dirty_o),
    .cache_tag_o    (cache_tag_o),
    .cache_data_o   (cache_data_o),
    .cache_valid_i  (cache_valid_i),
    .cache_dirty_i  (cache_dirty_i),
    .cache_tag_i    (cache_tag_i),
    .cache_data_i   (cache_data_i),
    .mem_enable_o   (mem_enable_o),
    .mem_write_o    (mem_write_o),
    .mem_addr_o     (mem_addr_o),
    .mem_data_o     (mem_data_o),
    .mem_ack_i      (mem_ack_i),
    .mem_data_i     (mem_data_i)
  );

  // Cache array storage (not cleared by reset).
  logic          arr_valid [32] = '{default: 1'b0};
  logic          arr_dirty [32] = '{default: 1'b0};
  logic [21:0]   arr_tag   [32] = '{default: '0};
  logic [255:0]  arr_data  [32] = '{default: '0};

  assign cache_valid_i = arr_valid[cache_index_o];
  assign cache_dirty_i = arr_dirty[cache_index_o];
  assign cache_tag_i   = arr_tag[cache_index_o];
  assign cache_data_i  = arr_data[cache_index_o];

  always @(posedge clock_i) begin
    if (cache_enable_o && cache_write_o) begin
      arr_valid[cache_index_o] <= cache_valid_o;
      arr_dirty[cache_index_o] <= cache_dirty_o;
      arr_tag[cache_index_o]   <= cache_tag_o;
      arr_data[cache_index_o]  <= cache_data_o;
    end
  end

  // Backing memory (line granular) and reference state.
  logic [255:0]  mem_lines [logic [31:0]];
  logic [31:0]   ref_mem   [logic [31:0]];
  bit            ref_valid [32];
  bit            ref_dirty [32];
  logic [21:0]   ref_tag   [32];

  int n_assert = 0;
  int n_fail   = 0;

  // Results of the last access
  int            g_stall, g_nwb, g_nrd;
  logic [31:0]   g_wb_addr, g_rd_addr, g_rdata;
  logic          g_hit_wr, g_first_write;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] la);
    logic [255:0] l;
    if (mem_lines.exists(la)) return mem_lines[la];
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = init_word(la + 32'(w * 4));
    return l;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    if (ref_mem.exists(wa)) return ref_mem[wa];
    return init_word(wa);
  endfunction

  function automatic logic [255:0] rnd_line();
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = $urandom();
    return l;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents one CPU access and plays the memory with the given latency
  // (ack on the lat-th cycle of each request) until the stall clears.
  task automatic do_access(input bit wr, input logic [31:0] addr,
                           input logic [31:0] wd, input int lat);
    int cnt, guard;
    logic [31:0] taddr;
    bit first;
    @(negedge clock_i);
    cpu_req_i = 1'b1; cpu_write_i = wr; cpu_addr_i = addr; cpu_data_i = wd;
    g_stall = 0; g_nwb = 0; g_nrd = 0; g_first_write = 1'bx;
    cnt = 0; guard = 0; first = 1; taddr = '0;
    #1;
    while (stall_o === 1'b1 && guard < 1000) begin
      guard++;
      g_stall++;
      if (mem_enable_o === 1'b1) begin
        if (cnt == 0) begin
          taddr = mem_addr_o;
          if (first) begin g_first_write = mem_write_o; first = 0; end
        end
        cnt++;
        if (cnt >= lat) begin
          chk("mem_addr_stable", mem_addr_o, taddr);
          chk("mem_addr_aligned", mem_addr_o[4:0], 5'd0);
          if (mem_write_o) begin
            g_nwb++; g_wb_addr = mem_addr_o;
            mem_lines[mem_addr_o] = mem_data_o;
          end else begin
            g_nrd++; g_rd_addr = mem_addr_o;
            mem_data_i = mem_line(mem_addr_o);
          end
          mem_ack_i = 1'b1;
          cnt = 0;
        end
      end
      @(posedge clock_i);
      #1 mem_ack_i = 1'b0;
      mem_data_i = rnd_line();
      @(negedge clock_i);
      #1;
    end
    chk("stall_bounded", guard < 1000, 1'b1);
    g_rdata  = cpu_data_o;
    g_hit_wr = cache_write_o;
    @(posedge clock_i);
    #1;
    cpu_req_i = 1'b0; cpu_write_i = 1'b0;
  endtask

  // Access checked against the reference model, which is then updated.
  task automatic run_op(input bit wr, input logic [31:0] addr,
                        input logic [31:0] wd, input int lat);
    logic [4:0]  idx;
    logic [21:0] tag;
    bit hit, exp_wb;
    int exp_stall;
    logic [31:0] exp_rd;
    idx = addr[9:5];
    tag = addr[31:10];
    hit = ref_valid[idx] && (ref_tag[idx] == tag);
    exp_wb = !hit && ref_valid[idx] && ref_dirty[idx];
    exp_stall = hit ? 0 : (exp_wb ? 2*lat + 2 : lat + 2);
    exp_rd = ref_word(addr);
    do_access(wr, addr, wd, lat);
    chk("stall_cycles", g_stall, exp_stall);
    chk("writeback_count", g_nwb, exp_wb);
    chk("refill_count", g_nrd, !hit);
    if (exp_wb) chk("writeback_addr", g_wb_addr, {ref_tag[idx], idx, 5'b0});
    if (!hit) chk("refill_addr", g_rd_addr, {addr[31:5], 5'b0});
    if (!wr) chk("load_data", g_rdata, exp_rd);
    chk("hit_cycle_write", g_hit_wr, wr);
    if (!hit) begin
      ref_valid[idx] = 1'b1; ref_tag[idx] = tag; ref_dirty[idx] = 1'b0;
    end
    if (wr) begin
      ref_dirty[idx] = 1'b1;
      ref_mem[{addr[31:2], 2'b00}] = wd;
    end
    chk("array_tag", arr_tag[idx], ref_tag[idx]);
    chk("array_dirty", arr_dirty[idx], ref_dirty[idx]);
  endtask

  initial begin
    logic [255:0] seed_line;
    int guard;

    // Reset state
    repeat (2) @(negedge clock_i);
    #1;
    chk("reset_mem_enable", mem_enable_o, 1'b0);
    chk("reset_mem_addr", mem_addr_o, 32'h0);
    rst_i = 1'b1;
    @(negedge clock_i);
    #1;
    chk("idle_stall", stall_o, 1'b0);
    chk("idle_cache_write", cache_write_o, 1'b0);
    chk("idle_mem_enable", mem_enable_o, 1'b0);
    chk("idle_mem_write", mem_write_o, 1'b0);
    chk("idle_mem_data", mem_data_o, 256'h0);

    // Cold load 0x420 with word1 seeded to 0xDEADBEEF, 10-cycle memory
    seed_line = mem_line(32'h420);
    seed_line[63:32] = 32'hDEAD_BEEF;
    mem_lines[32'h420] = seed_line;
    ref_mem[32'h424]   = 32'hDEAD_BEEF;
    run_op(1'b0, 32'h0000_0424, 32'h0, 10);
    chk("cold_load_stall", g_stall, 12);
    chk("cold_load_data", g_rdata, 32'hDEAD_BEEF);
    chk("cold_first_op_read", g_first_write, 1'b0);

    // Store hit
    run_op(1'b1, 32'h0000_0424, 32'h1234_5678, 3);
    chk("store_hit_stall", g_stall, 0);
    chk("store_hit_word", arr_data[1][63:32], 32'h1234_5678);
    chk("store_hit_dirty", arr_dirty[1], 1'b1);

    // Dirty conflict miss: writeback of the updated line, then refill
    run_op(1'b0, 32'h0000_0820, 32'h0, 4);
    chk("wb_line_word1", mem_line(32'h420) >> 32, {224'h0, 32'h1234_5678} | ((mem_line(32'h420) >> 64) << 32));
    chk("dirty_miss_first_op_write", g_first_write, 1'b1);
    chk("after_refill_dirty", arr_dirty[1], 1'b0);

    // Clean conflict miss: no writeback, first request is a read
    run_op(1'b0, 32'h0000_0C20, 32'h0, 3);
    chk("clean_miss_first_op_read", g_first_write, 1'b0);

    // Asynchronous reset in the middle of a refill
    @(negedge clock_i);
    cpu_req_i = 1'b1; cpu_write_i = 1'b0; cpu_addr_i = 32'h0000_1020;
    guard = 0;
    #1;
    while (mem_enable_o !== 1'b1 && guard < 20) begin
      @(negedge clock_i);
      #1;
      guard++;
    end
    chk("refill_started", mem_enable_o, 1'b1);
    chk("refill_is_read", mem_write_o, 1'b0);
    @(negedge clock_i);
    rst_i = 1'b0;
    #1;
    chk("rst_mem_enable", mem_enable_o, 1'b0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    cpu_req_i = 1'b0;
    #1;
    chk("rst_stall", stall_o, 1'b0);
    chk("rst_cache_write", cache_write_o, 1'b0);
    @(negedge clock_i);
    rst_i = 1'b1;
    #1;
    chk("rst_array_tag", arr_tag[1], 22'd3);
    chk("rst_array_valid", arr_valid[1], 1'b1);
    run_op(1'b0, 32'h0000_0C24, 32'h0, 2);
    chk("post_reset_hit_stall", g_stall, 0);

    // Spurious ack in IDLE
    @(negedge clock_i);
    mem_ack_i = 1'b1;
    mem_data_i = rnd_line();
    #1;
    chk("spurious_ack_cache_write", cache_write_o, 1'b0);
    @(posedge clock_i);
    #1 mem_ack_i = 1'b0;
    @(negedge clock_i);
    #1;
    chk("spurious_ack_mem_enable", mem_enable_o, 1'b0);
    chk("spurious_ack_stall", stall_o, 1'b0);
    chk("spurious_ack_cache_write_after", cache_write_o, 1'b0);
    run_op(1'b0, 32'h0000_0C20, 32'h0, 2);
    chk("spurious_ack_hit_stall", g_stall, 0);

    // Randomised traffic over 4 indices x 4 tags
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      a = '0;
      a[31:10] = 22'($urandom_range(0, 3));
      a[9:5]   = 5'($urandom_range(0, 3));
      a[4:2]   = 3'($urandom_range(0, 7));
      run_op(1'($urandom_range(0, 1)), a, $urandom(), $urandom_range(1, 5));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Sequences the 32-line direct-mapped data cache array (per line: valid, dirty, 22-bit tag, 256-bit data) between the CPU load/store stage and a 256-bit-line data memory.
- Serves hits combinationally and stalls the CPU on a miss.
- On a miss, writes back a dirty victim, refills the line, then replays the access.
- Write policy: write-back, write-allocate.

Parameters:
- ADDR_W, 32, CPU byte-address width.
- LINE_W, 256, cache line / memory burst width in bits.
- WORD_W, 32, CPU data word width.

Ports:
- clock_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- cpu_req_i  in  1  CPU access valid; held until stall_o is low.
- cpu_write_i  in  1  1 = store, 0 = load.
- cpu_addr_i  in  32  byte address: tag [31:10], index [9:5], word [4:2].
- cpu_data_i  in  32  store data.
- cpu_data_o  out  32  load data; valid when cpu_req_i=1 and stall_o=0.
- stall_o  out  1  CPU stall.
- cache_enable_o  out  1  cache array enable.
- cache_write_o  out  1  cache array write strobe.
- cache_index_o  out  5  line index.
- cache_valid_o  out  1  valid bit to write.
- cache_dirty_o  out  1  dirty bit to write.
- cache_tag_o  out  22  tag to write.
- cache_data_o  out  256  line to write.
- cache_valid_i  in  1  stored valid bit.
- cache_dirty_i  in  1  stored dirty bit.
- cache_tag_i  in  22  stored tag.
- cache_data_i  in  256  stored line.
- mem_enable_o  out  1  memory request; held until mem_ack_i.
- mem_write_o  out  1  1 = line write, 0 = line read.
- mem_addr_o  out  32  line-aligned address; bits [4:0] are 0.
- mem_data_o  out  256  writeback line.
- mem_ack_i  in  1  one-cycle completion pulse; mem_data_i is valid on a read ack.
- mem_data_i  in  256  refill line.

Behaviour:
- States: IDLE, WRITEBACK, REFILL, ALLOCATE.
- Reset (rst_i=0, asynchronous): state=IDLE; mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0; refill buffer cleared.
- After reset, stall_o is 0 while cpu_req_i=0; cache_write_o is 0.
- cache_enable_o = cpu_req_i | (state != IDLE); cache_index_o = cpu_addr_i[9:5] in every state.
- hit = cache_valid_i & (cache_tag_i == cpu_addr_i[31:10]).
- IDLE, request with hit: stall_o=0 in the same cycle.
  - Load: cpu_data_o = cache_data_i[32*w +: 32], where w = addr[4:2].
  - Store: cache_write_o=1 for that cycle; valid=1, dirty=1, tag unchanged; data = stored line with word w replaced by cpu_data_i.
  - No state change.
- IDLE, request with miss: stall_o=1 combinationally. Next state is WRITEBACK if cache_valid_i & cache_dirty_i, otherwise REFILL.
- WRITEBACK:
  - mem_enable_o=1, mem_write_o=1.
  - mem_addr_o = {cache_tag_i, index, 5'b0}; mem_data_o = cache_data_i.
  - Stay until mem_ack_i, then go to REFILL.
- REFILL:
  - mem_enable_o=1, mem_write_o=0; mem_addr_o = {addr[31:5], 5'b0}.
  - On mem_ack_i, latch mem_data_i into the refill buffer and go to ALLOCATE.
- ALLOCATE (exactly 1 cycle):
  - cache_write_o=1 with valid=1, dirty=0, tag = addr[31:10], data = refill buffer.
  - Next state is IDLE, where the access replays as a hit: a load returns data, a store merges and sets dirty.
- stall_o = 1 in every non-IDLE state.
- Miss latency without writeback: 1 (IDLE) + memory cycles + 1 (ALLOCATE) before the hit cycle.
- mem_enable_o and mem_addr_o must stay stable from request to ack; the memory side has no back-to-back requests without a state change.
- A mem_ack_i arriving in IDLE or ALLOCATE is ignored.
- cpu_addr_i, cpu_write_i and cpu_data_i must stay stable while stall_o=1. The controller does not latch them; this is a checker assertion on the bench.
- If cpu_req_i drops in WRITEBACK or REFILL, the memory transaction still completes and the line is allocated; no replay follows.
- An asynchronous reset mid-miss aborts the transaction: mem_enable_o goes low immediately; cache contents are untouched.

Test Plan:
- Cold load addr 0x0000_0420 (index 1, tag 1): REFILL to mem_addr 0x420, mem ack after 10 cycles with word1 = 0xDEADBEEF → allocate, then hit returns 0xDEADBEEF; stall_o high 12 cycles.
- Store hit to 0x424 with 0x12345678 → no stall, cache_write_o for 1 cycle, dirty=1, line word1 = 0x12345678.
- Load 0x0000_0820 (same index, tag 2) to the dirty line → WRITEBACK to mem_addr 0x420 with the updated line, then REFILL from 0x820, then hit; dirty=0.
- Clean conflict miss → no WRITEBACK state; the first memory request is a read.
- rst_i low during REFILL → mem_enable_o=0 and state=IDLE immediately; stall_o=0 with cpu_req_i=0.
- Spurious mem_ack_i in IDLE → no state change, no cache write.
